// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase scheduler with pedestrian walk service.
// Owns the one-second prescaler, per-phase countdown and all lamp outputs.
module traffic_phase_ctrl #(
  parameter int CLK_HZ      = 100000000,
  parameter int T_GREEN     = 20,
  parameter int T_YELLOW    = 5,
  parameter int T_ALLRED    = 2,
  parameter int T_MIN_GREEN = 5,
  parameter int T_PED       = 5
) (
  input  logic       CLK100MHZ,
  input  logic       RST,
  input  logic       ped_req_a,
  input  logic       ped_req_b,
  output logic       red_a,
  output logic       yel_a,
  output logic       grn_a,
  output logic       red_b,
  output logic       yel_b,
  output logic       grn_b,
  output logic       walk_a,
  output logic       walk_b,
  output logic [5:0] seconds_left,
  output logic [2:0] phase,
  output logic       sec_tick
);

  localparam int              PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PCNT_MAX = PW'(CLK_HZ - 1);
  localparam logic [5:0]      D_GREEN  = 6'(T_GREEN);
  localparam logic [5:0]      D_YELLOW = 6'(T_YELLOW);
  localparam logic [5:0]      D_ALLRED = 6'(T_ALLRED);
  // Countdown values at which the k-th tick of a green equals T_MIN_GREEN / T_PED.
  localparam logic [5:0]      CUT_SL   = 6'(T_GREEN + 1 - T_MIN_GREEN);
  localparam logic [5:0]      PED_SL   = 6'(T_GREEN + 1 - T_PED);

  typedef enum logic [2:0] {
    ALLRED_TO_A = 3'd0,
    GREEN_A     = 3'd1,
    YELLOW_A    = 3'd2,
    ALLRED_TO_B = 3'd3,
    GREEN_B     = 3'd4,
    YELLOW_B    = 3'd5
  } state_t;

  state_t        state_reg, state_next, succ;
  logic [PW-1:0] pcnt_reg;
  logic [5:0]    sec_reg, sec_next;
  logic          pend_a_reg, pend_a_next, pend_b_reg, pend_b_next;
  logic          walk_a_reg, walk_a_next, walk_b_reg, walk_b_next;
  logic [5:0]    lamps_reg, lamps_next;
  logic          illegal, cut, drop_a, drop_b;

  function automatic logic [5:0] dur_of(input state_t s);
    case (s)
      GREEN_A, GREEN_B:   dur_of = D_GREEN;
      YELLOW_A, YELLOW_B: dur_of = D_YELLOW;
      default:            dur_of = D_ALLRED;
    endcase
  endfunction

  assign sec_tick = (pcnt_reg == PCNT_MAX);

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      pcnt_reg   <= '0;
      state_reg  <= ALLRED_TO_A;
      sec_reg    <= D_ALLRED;
      pend_a_reg <= 1'b0;
      pend_b_reg <= 1'b0;
      walk_a_reg <= 1'b0;
      walk_b_reg <= 1'b0;
      lamps_reg  <= 6'b100100;
    end else begin
      pcnt_reg   <= sec_tick ? '0 : pcnt_reg + 1'b1;
      state_reg  <= state_next;
      sec_reg    <= sec_next;
      pend_a_reg <= pend_a_next;
      pend_b_reg <= pend_b_next;
      walk_a_reg <= walk_a_next;
      walk_b_reg <= walk_b_next;
      lamps_reg  <= lamps_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sec_next    = sec_reg;
    pend_a_next = pend_a_reg;
    pend_b_next = pend_b_reg;
    walk_a_next = walk_a_reg;
    walk_b_next = walk_b_reg;
    lamps_next  = 6'b100100;
    succ        = ALLRED_TO_A;
    illegal     = 1'b0;
    cut         = 1'b0;

    case (state_reg)
      ALLRED_TO_A: succ = GREEN_A;
      GREEN_A: begin
        succ = YELLOW_A;
        cut  = pend_a_reg && (sec_reg <= CUT_SL);
      end
      YELLOW_A:    succ = ALLRED_TO_B;
      ALLRED_TO_B: succ = GREEN_B;
      GREEN_B: begin
        succ = YELLOW_B;
        cut  = pend_b_reg && (sec_reg <= CUT_SL);
      end
      YELLOW_B:    succ = ALLRED_TO_A;
      default:     illegal = 1'b1;
    endcase

    if (illegal) begin
      state_next = ALLRED_TO_A;
      sec_next   = D_ALLRED;
    end else if (sec_tick) begin
      if (sec_reg <= 6'd1 || cut) begin
        state_next = succ;
        sec_next   = dur_of(succ);
      end else begin
        sec_next = sec_reg - 6'd1;
      end
    end

    // A walk lamp goes dark on its T_PED-th tick, or whenever its green ends.
    drop_a = walk_a_reg && (state_reg == GREEN_B) && sec_tick &&
             ((sec_reg == PED_SL) || (state_next != GREEN_B));
    drop_b = walk_b_reg && (state_reg == GREEN_A) && sec_tick &&
             ((sec_reg == PED_SL) || (state_next != GREEN_A));

    if (ped_req_a && (!walk_a_reg || drop_a)) pend_a_next = 1'b1;
    if (ped_req_b && (!walk_b_reg || drop_b)) pend_b_next = 1'b1;
    if (drop_a) walk_a_next = 1'b0;
    if (drop_b) walk_b_next = 1'b0;

    // Serving on green entry overrides the capture above, so a same-cycle request is consumed.
    if (state_next == GREEN_B && state_reg != GREEN_B && (pend_a_reg || ped_req_a)) begin
      walk_a_next = 1'b1;
      pend_a_next = 1'b0;
    end
    if (state_next == GREEN_A && state_reg != GREEN_A && (pend_b_reg || ped_req_b)) begin
      walk_b_next = 1'b1;
      pend_b_next = 1'b0;
    end

    // Lamp order: {red_a, yel_a, grn_a, red_b, yel_b, grn_b}
    case (state_next)
      GREEN_A:  lamps_next = 6'b001100;
      YELLOW_A: lamps_next = 6'b010100;
      GREEN_B:  lamps_next = 6'b100001;
      YELLOW_B: lamps_next = 6'b100010;
      default:  lamps_next = 6'b100100;
    endcase
  end

  assign {red_a, yel_a, grn_a, red_b, yel_b, grn_b} = lamps_reg;
  assign walk_a       = walk_a_reg;
  assign walk_b       = walk_b_reg;
  assign seconds_left = sec_reg;
  assign phase        = state_reg;

endmodule
